// File: rtl/vram_access_arbiter_pkg.sv
// Shared encodings for the VRAM access arbiter: clear FSM states and the
// per-cycle grant selection driving the RAM port mux.
package vram_access_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CLR  = 2'd2,
    GNT_WR   = 2'd3
  } gnt_e;

endpackage

// File: rtl/vram_access_arbiter_if.sv
// Requester/RAM-side bundle of the VRAM arbiter. slave = arbiter view,
// master = environment view (VGA timing, painter, RAM macro).
interface vram_access_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 3
);
  logic              iDispReq;
  logic [ADDR_W-1:0] iDispAddr;
  logic [DATA_W-1:0] oDispData;
  logic              oDispValid;
  logic              iWrReq;
  logic [ADDR_W-1:0] iWrAddr;
  logic [DATA_W-1:0] iWrData;
  logic              oWrAck;
  logic              iClearStart;
  logic [DATA_W-1:0] iClearColor;
  logic              oClearBusy;
  logic              oClearDone;
  logic [ADDR_W-1:0] oRamAddr;
  logic              oRamWe;
  logic [DATA_W-1:0] oRamWData;
  logic [DATA_W-1:0] iRamRData;

  modport slave (
    input  iDispReq, iDispAddr, iWrReq, iWrAddr, iWrData,
           iClearStart, iClearColor, iRamRData,
    output oDispData, oDispValid, oWrAck, oClearBusy, oClearDone,
           oRamAddr, oRamWe, oRamWData
  );

  modport master (
    output iDispReq, iDispAddr, iWrReq, iWrAddr, iWrData,
           iClearStart, iClearColor, iRamRData,
    input  oDispData, oDispValid, oWrAck, oClearBusy, oClearDone,
           oRamAddr, oRamWe, oRamWData
  );
endinterface

// File: rtl/vram_clear_counter.sv
// Address sweep counter for the clear engine: load-to-zero, count enable,
// terminal count at the all-ones address. Wraps naturally.
module vram_clear_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_zero_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              tc_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_zero_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign tc_o    = &cnt_q;

endmodule

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM arbiter: display reads > clear sweep > painter writes.
// All RAM-side outputs are registered; display data returns 3 cycles after request.
module vram_access_arbiter
  import vram_access_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 3
) (
  input logic                  Clock,
  input logic                  Reset,
  vram_access_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] color_q, color_d;
  gnt_e              gnt;
  logic              clr_load, clr_en, clr_tc;
  logic [ADDR_W-1:0] clr_cnt;

  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              wr_ack_q;
  logic              clr_done_q;
  logic              vld_p0_q, vld_p1_q, vld_p2_q;
  logic [DATA_W-1:0] disp_data_p2_q;

  // Grant and clear FSM next state
  always_comb begin
    state_d  = state_q;
    color_d  = color_q;
    clr_load = 1'b0;
    gnt      = GNT_NONE;

    if (bus.iDispReq)
      gnt = GNT_DISP;
    else if (state_q == ST_CLEAR)
      gnt = GNT_CLR;
    else if (bus.iWrReq && !wr_ack_q)
      gnt = GNT_WR;  // ack guard stops a held request writing twice

    case (state_q)
      ST_IDLE: begin
        if (bus.iClearStart) begin
          state_d  = ST_CLEAR;
          color_d  = bus.iClearColor;
          clr_load = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (gnt == GNT_CLR && clr_tc)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_en = (gnt == GNT_CLR);

  vram_clear_counter #(.ADDR_W(ADDR_W)) u_clr_cnt (
    .clk         (Clock),
    .rst_n       (Reset),
    .load_zero_i (clr_load),
    .en_i        (clr_en),
    .count_o     (clr_cnt),
    .tc_o        (clr_tc)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
    end
  end

  // RAM port registers: idle cycles hold the address with write disabled
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      ram_we_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      clr_done_q <= 1'b0;
      case (gnt)
        GNT_DISP: ram_addr_q <= bus.iDispAddr;
        GNT_CLR: begin
          ram_addr_q  <= clr_cnt;
          ram_we_q    <= 1'b1;
          ram_wdata_q <= color_q;
          clr_done_q  <= clr_tc;
        end
        GNT_WR: begin
          ram_addr_q  <= bus.iWrAddr;
          ram_we_q    <= 1'b1;
          ram_wdata_q <= bus.iWrData;
          wr_ack_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Display return path: p0 address out, p1 RAM read, p2 data registered
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vld_p0_q       <= 1'b0;
      vld_p1_q       <= 1'b0;
      vld_p2_q       <= 1'b0;
      disp_data_p2_q <= '0;
    end else begin
      vld_p0_q <= bus.iDispReq;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q)
        disp_data_p2_q <= bus.iRamRData;
    end
  end

  assign bus.oRamAddr   = ram_addr_q;
  assign bus.oRamWe     = ram_we_q;
  assign bus.oRamWData  = ram_wdata_q;
  assign bus.oWrAck     = wr_ack_q;
  assign bus.oClearDone = clr_done_q;
  assign bus.oClearBusy = (state_q == ST_CLEAR);
  assign bus.oDispValid = vld_p2_q;
  assign bus.oDispData  = disp_data_p2_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench: a 16-bit-address arbiter for display/painter paths and a
// 4-bit-address arbiter for full clear sweeps, each with a small RAM model.
module tb_vram_access_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vram_access_arbiter_if #(.ADDR_W(16), .DATA_W(3)) bus16 ();
  vram_access_arbiter_if #(.ADDR_W(4),  .DATA_W(3)) bus4 ();

  vram_access_arbiter #(.ADDR_W(16), .DATA_W(3)) dut16 (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus16)
  );

  vram_access_arbiter #(.ADDR_W(4), .DATA_W(3)) dut4 (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  logic [2:0] mem4 [0:15];

  always @(posedge clk) begin
    bus16.iRamRData <= (bus16.oRamAddr == 16'd5) ? 3'b101 : bus16.oRamAddr[2:0];
    if (bus4.oRamWe)
      mem4[bus4.oRamAddr] <= bus4.oRamWData;
    bus4.iRamRData <= mem4[bus4.oRamAddr];
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus16.oDispValid, bus16.oDispData, bus16.oWrAck, bus16.oClearBusy, bus16.oClearDone,
         bus16.oRamWe, bus16.oRamAddr, bus16.oRamWData} !== 28'd0) begin
      errors++;
      $display("FAIL reset16: outputs not all zero (addr=%0h we=%0b)", bus16.oRamAddr, bus16.oRamWe);
    end
    checks++;
    if ({bus4.oDispValid, bus4.oDispData, bus4.oWrAck, bus4.oClearBusy, bus4.oClearDone,
         bus4.oRamWe, bus4.oRamAddr, bus4.oRamWData} !== 16'd0) begin
      errors++;
      $display("FAIL reset4: outputs not all zero (addr=%0h we=%0b)", bus4.oRamAddr, bus4.oRamWe);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_display();
    bus16.iDispReq  = 1'b1;
    bus16.iDispAddr = 16'd5;
    @(negedge clk);
    bus16.iDispReq = 1'b0;
    checks++;
    if ({bus16.oRamWe, bus16.oRamAddr} !== {1'b0, 16'd5}) begin
      errors++;
      $display("FAIL disp_addr: got we=%0b addr=%0h, want we=0 addr=5", bus16.oRamWe, bus16.oRamAddr);
    end
    @(negedge clk);
    checks++;
    if (bus16.oDispValid !== 1'b0) begin
      errors++;
      $display("FAIL disp_early: valid=%0b, want 0", bus16.oDispValid);
    end
    @(negedge clk);
    checks++;
    if ({bus16.oDispValid, bus16.oDispData, bus16.oRamWe} !== {1'b1, 3'b101, 1'b0}) begin
      errors++;
      $display("FAIL disp_data: valid=%0b data=%0b we=%0b, want 1 101 0",
               bus16.oDispValid, bus16.oDispData, bus16.oRamWe);
    end
    @(negedge clk);
    checks++;
    if (bus16.oDispValid !== 1'b0) begin
      errors++;
      $display("FAIL disp_late: valid=%0b, want 0", bus16.oDispValid);
    end
  endtask

  task automatic test_write();
    bus16.iWrReq  = 1'b1;
    bus16.iWrAddr = 16'h0102;
    bus16.iWrData = 3'b010;
    @(negedge clk);
    checks++;
    if ({bus16.oWrAck, bus16.oRamWe, bus16.oRamAddr, bus16.oRamWData} !== {1'b1, 1'b1, 16'h0102, 3'b010}) begin
      errors++;
      $display("FAIL wr_ack: ack=%0b we=%0b addr=%0h data=%0b, want 1 1 0102 010",
               bus16.oWrAck, bus16.oRamWe, bus16.oRamAddr, bus16.oRamWData);
    end
    @(negedge clk);
    checks++;
    if ({bus16.oWrAck, bus16.oRamWe} !== 2'b00) begin
      errors++;
      $display("FAIL wr_double: ack=%0b we=%0b, want 0 0", bus16.oWrAck, bus16.oRamWe);
    end
    bus16.iWrReq = 1'b0;
    @(negedge clk);
    checks++;
    if (bus16.oWrAck !== 1'b0) begin
      errors++;
      $display("FAIL wr_drop: ack=%0b, want 0", bus16.oWrAck);
    end
    // display beats painter; painter then withdraws
    bus16.iDispReq  = 1'b1;
    bus16.iDispAddr = 16'h0200;
    bus16.iWrReq    = 1'b1;
    bus16.iWrAddr   = 16'h0300;
    bus16.iWrData   = 3'b111;
    @(negedge clk);
    bus16.iDispReq = 1'b0;
    bus16.iWrReq   = 1'b0;
    checks++;
    if ({bus16.oWrAck, bus16.oRamWe, bus16.oRamAddr} !== {1'b0, 1'b0, 16'h0200}) begin
      errors++;
      $display("FAIL wr_prio: ack=%0b we=%0b addr=%0h, want 0 0 0200",
               bus16.oWrAck, bus16.oRamWe, bus16.oRamAddr);
    end
    @(negedge clk);
    checks++;
    if ({bus16.oWrAck, bus16.oRamWe, bus16.oRamAddr} !== {1'b0, 1'b0, 16'h0200}) begin
      errors++;
      $display("FAIL wr_withdraw: ack=%0b we=%0b addr=%0h, want 0 0 0200",
               bus16.oWrAck, bus16.oRamWe, bus16.oRamAddr);
    end
  endtask

  task automatic test_clear_basic();
    int bad;
    bus4.iClearStart = 1'b1;
    bus4.iClearColor = 3'b100;
    @(negedge clk);
    bus4.iClearStart = 1'b0;
    checks++;
    if ({bus4.oClearBusy, bus4.oRamWe} !== 2'b10) begin
      errors++;
      $display("FAIL clr_start: busy=%0b we=%0b, want 1 0", bus4.oClearBusy, bus4.oRamWe);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({bus4.oRamWe, bus4.oRamAddr, bus4.oRamWData, bus4.oClearDone} !==
          {1'b1, 4'(i), 3'b100, (i == 15)}) begin
        errors++;
        $display("FAIL clr_write%0d: we=%0b addr=%0d data=%0b done=%0b",
                 i, bus4.oRamWe, bus4.oRamAddr, bus4.oRamWData, bus4.oClearDone);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus4.oClearBusy, bus4.oRamWe, bus4.oClearDone} !== 3'b000) begin
      errors++;
      $display("FAIL clr_end: busy=%0b we=%0b done=%0b, want 0 0 0",
               bus4.oClearBusy, bus4.oRamWe, bus4.oClearDone);
    end
    bad = 0;
    for (int a = 0; a < 16; a++)
      if (mem4[a] !== 3'b100) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clr_mem: %0d words differ, want 0", bad);
    end
  endtask

  task automatic test_clear_stall();
    logic hist [0:63];
    int   exp_addr = 0;
    int   wcount   = 0;
    int   done_at  = -1;
    for (int k = 0; k < 64; k++) hist[k] = 1'b0;
    bus4.iClearStart = 1'b1;
    bus4.iClearColor = 3'b011;
    bus4.iDispAddr   = 4'hA;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus4.iClearStart = 1'b0;
      if (bus4.oRamWe) begin
        checks++;
        if (bus4.oRamAddr !== 4'(exp_addr)) begin
          errors++;
          $display("FAIL stall_addr@%0d: got %0d want %0d", k, bus4.oRamAddr, exp_addr);
        end
        exp_addr++;
        wcount++;
      end
      if (bus4.oClearDone) done_at = k;
      if (hist[k-1]) begin
        checks++;
        if ({bus4.oRamWe, bus4.oRamAddr} !== {1'b0, 4'hA}) begin
          errors++;
          $display("FAIL stall_disp@%0d: we=%0b addr=%0h, want 0 a", k, bus4.oRamWe, bus4.oRamAddr);
        end
      end
      checks++;
      if (bus4.oDispValid !== ((k >= 3) ? hist[k-3] : 1'b0)) begin
        errors++;
        $display("FAIL stall_valid@%0d: got %0b want %0b", k, bus4.oDispValid,
                 (k >= 3) ? hist[k-3] : 1'b0);
      end
      hist[k]       = (k <= 32) && (k % 2 == 1);
      bus4.iDispReq = hist[k];
    end
    checks++;
    if (wcount != 16 || done_at != 33 || bus4.oClearBusy !== 1'b0) begin
      errors++;
      $display("FAIL stall_sweep: writes=%0d done_at=%0d busy=%0b, want 16 33 0",
               wcount, done_at, bus4.oClearBusy);
    end
  endtask

  task automatic test_clear_with_write();
    int done_at = -1;
    int ack_at  = -1;
    int cwrites = 0;
    int badcol  = 0;
    bus4.iClearStart = 1'b1;
    bus4.iClearColor = 3'b001;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus4.oRamWe && !bus4.oWrAck) begin
        cwrites++;
        if (bus4.oRamWData !== 3'b001) badcol++;
      end
      if (bus4.oClearDone) done_at = k;
      if (bus4.oWrAck && ack_at < 0) begin
        ack_at = k;
        bus4.iWrReq = 1'b0;
        checks++;
        if ({bus4.oRamAddr, bus4.oRamWData} !== {4'd3, 3'b110}) begin
          errors++;
          $display("FAIL cw_ackdata: addr=%0d data=%0b, want 3 110", bus4.oRamAddr, bus4.oRamWData);
        end
      end
      bus4.iClearStart = (k == 5);
      bus4.iClearColor = (k == 5) ? 3'b111 : 3'b001;
      if (k == 1) begin
        bus4.iWrReq  = 1'b1;
        bus4.iWrAddr = 4'd3;
        bus4.iWrData = 3'b110;
      end
    end
    checks++;
    if (done_at != 17 || ack_at != 18) begin
      errors++;
      $display("FAIL cw_order: done_at=%0d ack_at=%0d, want 17 18", done_at, ack_at);
    end
    checks++;
    if (cwrites != 16 || badcol != 0) begin
      errors++;
      $display("FAIL cw_restart: clear writes=%0d bad colour=%0d, want 16 0", cwrites, badcol);
    end
    checks++;
    if (mem4[3] !== 3'b110) begin
      errors++;
      $display("FAIL cw_mem3: got %0b want 110", mem4[3]);
    end
  endtask

  task automatic test_reset_mid_clear();
    bit found = 0;
    bus4.iClearStart = 1'b1;
    bus4.iClearColor = 3'b010;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      bus4.iClearStart = 1'b0;
      if (bus4.oRamWe && bus4.oRamAddr == 4'd7) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_wait: address 7 write not seen within 30 cycles");
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus4.oRamWe, bus4.oClearBusy, bus4.oDispValid, bus4.oWrAck, bus4.oClearDone, bus4.oRamAddr} !== 9'd0) begin
      errors++;
      $display("FAIL rst_mid: we=%0b busy=%0b valid=%0b ack=%0b addr=%0d, want all 0",
               bus4.oRamWe, bus4.oClearBusy, bus4.oDispValid, bus4.oWrAck, bus4.oRamAddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus4.iClearStart = 1'b1;
    bus4.iClearColor = 3'b101;
    @(negedge clk);
    bus4.iClearStart = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({bus4.oRamWe, bus4.oRamAddr, bus4.oRamWData} !== {1'b1, 4'(i), 3'b101}) begin
        errors++;
        $display("FAIL rst_restart%0d: we=%0b addr=%0d data=%0b", i, bus4.oRamWe, bus4.oRamAddr, bus4.oRamWData);
      end
    end
  endtask

  initial begin
    bus16.iDispReq = 0; bus16.iDispAddr = '0; bus16.iWrReq = 0; bus16.iWrAddr = '0;
    bus16.iWrData = '0; bus16.iClearStart = 0; bus16.iClearColor = '0;
    bus4.iDispReq = 0; bus4.iDispAddr = '0; bus4.iWrReq = 0; bus4.iWrAddr = '0;
    bus4.iWrData = '0; bus4.iClearStart = 0; bus4.iClearColor = '0;
    test_reset();
    test_display();
    test_write();
    test_clear_basic();
    test_clear_stall();
    test_clear_with_write();
    test_reset_mid_clear();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
